// File: rtl/iter_mac_unit.sv
// Sequential shift-add multiply-accumulate, one multiplier bit per clock.
// Latency: B_W+1 edges from accept to done (EARLY_TERM=0), down to 2 edges with early termination.
// Backpressure: in_ready is high only in IDLE; in_valid is ignored while an op is in flight.
module iter_mac_unit #(
  parameter int A_W        = 7,
  parameter int B_W        = 8,
  parameter int ACC_W      = 24,
  parameter bit SAT        = 1'b1,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_W-1:0]       a,
  input  logic [B_W-1:0]       b,
  input  logic                 acc_mode,
  input  logic                 acc_clr,
  output logic [A_W+B_W-1:0]   prod,
  output logic [ACC_W-1:0]     acc,
  output logic                 done,
  output logic                 busy,
  output logic                 ovf
);

  localparam int P_W   = A_W + B_W;
  localparam int SUM_W = ACC_W + 1;
  localparam int CNT_W = $clog2(B_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [P_W-1:0]   a_sh;
  logic [P_W-1:0]   p;
  logic [B_W-1:0]   b_sh;
  logic [CNT_W-1:0] cnt;
  logic             mode_r;

  logic [B_W-1:0]   b_nxt;
  logic             last;
  logic [SUM_W-1:0] sum;

  // Next multiplier shift, termination test and the widened accumulate sum.
  always_comb begin
    b_nxt = b_sh >> 1;
    last  = (cnt == CNT_W'(B_W - 1)) || (EARLY_TERM && (b_nxt == '0));
    sum   = {1'b0, acc} + SUM_W'(p);
  end

  // Control FSM plus datapath; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      p        <= '0;
      cnt      <= '0;
      mode_r   <= 1'b0;
      prod     <= '0;
      acc      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      // A clear outside FIN wipes acc/ovf without disturbing an op in flight.
      if (acc_clr && (state != FIN)) begin
        acc <= '0;
        ovf <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= P_W'(a);
            b_sh     <= b;
            mode_r   <= acc_mode;
            p        <= '0;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (b_sh[0]) p <= p + a_sh;
          a_sh <= a_sh << 1;
          b_sh <= b_nxt;
          cnt  <= cnt + CNT_W'(1);
          if (last) state <= FIN;
        end
        FIN: begin
          prod     <= p;
          done     <= 1'b1;
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          // A coincident clear turns the op into a load and drops the overflow flag.
          if (acc_clr) begin
            acc <= ACC_W'(p);
            ovf <= 1'b0;
          end else if (mode_r) begin
            if (sum[ACC_W]) begin
              ovf <= 1'b1;
              acc <= SAT ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
            end else begin
              acc <= sum[ACC_W-1:0];
            end
          end else begin
            acc <= ACC_W'(p);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_mac_unit.sv
// Directed bench for iter_mac_unit across four parameter sets.
// Expected results come from a behavioural arithmetic model via a scoreboard queue.
// Every input is driven #1 after a rising edge; outputs are sampled at the same point.
module tb_iter_mac_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [6:0]  a;
  logic [7:0]  b;
  logic        acc_mode;
  logic [3:0]  acc_clr;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready, done, busy, ovf;
  logic [3:0][14:0] prod;
  logic [23:0] acc0, acc1;
  logic [14:0] acc2, acc3;

  // 0: defaults, 1: no early termination, 2: 15-bit saturating, 3: 15-bit wrapping
  iter_mac_unit u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a), .b(b), .acc_mode(acc_mode), .acc_clr(acc_clr[0]), .prod(prod[0]), .acc(acc0),
    .done(done[0]), .busy(busy[0]), .ovf(ovf[0]));
  iter_mac_unit #(.EARLY_TERM(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .a(a), .b(b), .acc_mode(acc_mode), .acc_clr(acc_clr[1]),
    .prod(prod[1]), .acc(acc1), .done(done[1]), .busy(busy[1]), .ovf(ovf[1]));
  iter_mac_unit #(.ACC_W(15), .SAT(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .a(a), .b(b), .acc_mode(acc_mode), .acc_clr(acc_clr[2]),
    .prod(prod[2]), .acc(acc2), .done(done[2]), .busy(busy[2]), .ovf(ovf[2]));
  iter_mac_unit #(.ACC_W(15), .SAT(1'b0)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]),
    .in_ready(in_ready[3]), .a(a), .b(b), .acc_mode(acc_mode), .acc_clr(acc_clr[3]),
    .prod(prod[3]), .acc(acc3), .done(done[3]), .busy(busy[3]), .ovf(ovf[3]));

  logic [1:0]  sel;
  logic        s_ready, s_done, s_busy, s_ovf;
  logic [14:0] s_prod;
  logic [23:0] s_acc;

  always_comb begin
    s_ready = in_ready[sel];
    s_done  = done[sel];
    s_busy  = busy[sel];
    s_ovf   = ovf[sel];
    s_prod  = prod[sel];
    case (sel)
      2'd0:    s_acc = acc0;
      2'd1:    s_acc = acc1;
      2'd2:    s_acc = {9'd0, acc2};
      default: s_acc = {9'd0, acc3};
    endcase
  end

  typedef struct {
    logic [14:0] prod;
    logic [23:0] acc;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t   sb[$];
  int     acc_edge[$];
  int     op_a[$];
  int     op_b[$];
  bit     op_m[$];

  longint m_acc[4];
  bit     m_ovf[4];
  int     accw[4]  = '{24, 24, 15, 15};
  bit     sat_p[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  bit     et_p[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int msb_idx(input int v);
    int m = 0;
    for (int i = 0; i < 32; i++) if (v[i]) m = i;
    return m;
  endfunction

  // Arithmetic model: computes the expected result of one op and queues it.
  task automatic push_op(input logic [1:0] i, input int av, input int bv, input bit mode);
    exp_t   e;
    longint pr;
    longint mx;
    longint s;
    pr = longint'(av) * longint'(bv);
    mx = (longint'(1) << accw[i]) - 1;
    if (mode) begin
      s = m_acc[i] + pr;
      if (s > mx) begin
        m_ovf[i] = 1'b1;
        m_acc[i] = sat_p[i] ? mx : (s % (mx + 1));
      end else begin
        m_acc[i] = s;
      end
    end else begin
      m_acc[i] = pr;
    end
    e.prod = pr[14:0];
    e.acc  = m_acc[i][23:0];
    e.ovf  = m_ovf[i];
    e.lat  = et_p[i] ? (((bv <= 1) ? 1 : msb_idx(bv) + 1) + 1) : 9;
    sb.push_back(e);
  endtask

  // Runs the queued ops on one instance with in_valid held high throughout.
  task automatic run_seq(input logic [1:0] i, input string tag);
    int   nops;
    int   k;
    int   ndone;
    int   edge_n;
    int   ae;
    bit   acc_now;
    exp_t e;
    nops = op_a.size(); k = 0; ndone = 0; edge_n = 0;
    sel = i;
    a = 7'(op_a[0]); b = 8'(op_b[0]); acc_mode = op_m[0];
    push_op(i, op_a[0], op_b[0], op_m[0]);
    in_valid[i] = 1'b1;
    while (ndone < nops && edge_n < 200) begin
      acc_now = in_valid[i] && s_ready;
      @(posedge clk); #1;
      edge_n++;
      if (acc_now) begin
        acc_edge.push_back(edge_n);
        k++;
        if (k < nops) begin
          a = 7'(op_a[k]); b = 8'(op_b[k]); acc_mode = op_m[k];
          push_op(i, op_a[k], op_b[k], op_m[k]);
        end else begin
          in_valid[i] = 1'b0;
        end
      end
      if (s_done) begin
        e  = sb.pop_front();
        ae = acc_edge.pop_front();
        chk({tag, " prod"}, 64'(s_prod), 64'(e.prod));
        chk({tag, " acc"}, 64'(s_acc), 64'(e.acc));
        chk({tag, " ovf"}, 64'(s_ovf), 64'(e.ovf));
        chk({tag, " latency"}, 64'(edge_n - ae), 64'(e.lat));
        chk({tag, " ready on done"}, 64'(s_ready), 64'd1);
        ndone++;
      end
    end
    chk({tag, " ops completed"}, 64'(ndone), 64'(nops));
    in_valid[i] = 1'b0;
    sb.delete(); acc_edge.delete();
    op_a.delete(); op_b.delete(); op_m.delete();
    @(posedge clk); #1;
    chk({tag, " done one cycle"}, 64'(s_done), 64'd0);
  endtask

  task automatic add_op(input int av, input int bv, input bit mode);
    op_a.push_back(av); op_b.push_back(bv); op_m.push_back(mode);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int   no_done;

  initial begin
    rst_n = 1'b0; in_valid = '0; acc_clr = '0; a = '0; b = '0; acc_mode = 1'b0; sel = 2'd0;
    for (int i = 0; i < 4; i++) begin m_acc[i] = 0; m_ovf[i] = 1'b0; end
    repeat (2) @(posedge clk);
    #1;
    chk("reset prod", 64'(s_prod), 64'd0);
    chk("reset acc", 64'(s_acc), 64'd0);
    chk("reset done", 64'(s_done), 64'd0);
    chk("reset busy", 64'(s_busy), 64'd0);
    chk("reset ovf", 64'(s_ovf), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready after reset", 64'(s_ready), 64'd1);

    // Full-length iteration without early termination.
    add_op(127, 255, 1'b0);
    run_seq(2'd1, "full_iter");

    // Early termination on tiny multipliers.
    add_op(100, 1, 1'b0);
    run_seq(2'd0, "b_one");
    add_op(100, 0, 1'b0);
    run_seq(2'd0, "b_zero");

    // Back-to-back accumulate chain: 15, 39, 53.
    add_op(3, 5, 1'b0);
    add_op(4, 6, 1'b1);
    add_op(7, 2, 1'b1);
    run_seq(2'd0, "chain");
    chk("chain final acc", 64'(acc0), 64'd53);

    // Reset in the middle of an op.
    sel = 2'd0; a = 7'd5; b = 8'd3; acc_mode = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    chk("mid-run busy", 64'(s_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort prod", 64'(s_prod), 64'd0);
    chk("abort acc", 64'(s_acc), 64'd0);
    chk("abort busy", 64'(s_busy), 64'd0);
    chk("abort done", 64'(s_done), 64'd0);
    chk("abort ovf", 64'(s_ovf), 64'd0);
    for (int i = 0; i < 4; i++) begin m_acc[i] = 0; m_ovf[i] = 1'b0; end
    @(posedge clk); #1;
    rst_n = 1'b1;
    no_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (s_done) no_done++;
    end
    chk("abort no done", 64'(no_done), 64'd0);
    chk("abort ready", 64'(s_ready), 64'd1);

    // Overflow: saturating and wrapping 15-bit accumulators.
    add_op(127, 255, 1'b0);
    add_op(127, 255, 1'b1);
    run_seq(2'd2, "sat");
    chk("sat acc const", 64'(acc2), 64'd32767);
    add_op(127, 255, 1'b0);
    add_op(127, 255, 1'b1);
    run_seq(2'd3, "wrap");
    chk("wrap acc const", 64'(acc3), 64'd32002);

    // Clear while idle.
    sel = 2'd3; acc_clr[3] = 1'b1;
    @(posedge clk); #1;
    acc_clr[3] = 1'b0; m_acc[3] = 0; m_ovf[3] = 1'b0;
    chk("idle clr acc", 64'(s_acc), 64'd0);
    chk("idle clr ovf", 64'(s_ovf), 64'd0);

    // A load leaves the sticky overflow flag alone.
    add_op(100, 10, 1'b0);
    run_seq(2'd2, "load keeps ovf");

    // Clear coincident with FIN of an accumulate: becomes a load.
    sel = 2'd2; a = 7'd4; b = 8'd5; acc_mode = 1'b1; in_valid[2] = 1'b1;
    chk("fin clr ready", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("fin clr pre busy", 64'(s_busy), 64'd1);
    chk("fin clr pre acc", 64'(s_acc), 64'd1000);
    acc_clr[2] = 1'b1;
    @(posedge clk); #1;
    acc_clr[2] = 1'b0;
    chk("fin clr done", 64'(s_done), 64'd1);
    chk("fin clr prod", 64'(s_prod), 64'd20);
    chk("fin clr acc", 64'(s_acc), 64'd20);
    chk("fin clr ovf", 64'(s_ovf), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
